// File: rtl/iq_hist_pkg.sv
// iq_hist_pkg: shared state encoding and binning helpers for the I/Q histogram correlator
package iq_hist_pkg;

    typedef enum logic [2:0] {IDLE, ACCUM, MAC, DONE, CLEAR} state_t;

    function automatic logic in_range(input int i, input int q, input int x_min, input int y_min,
                                      input int grid);
        return (i >= x_min) && (i < x_min + grid) && (q >= y_min) && (q < y_min + grid);
    endfunction

    function automatic int bin_idx(input int i, input int q, input int x_min, input int y_min,
                                   input int grid);
        return (q - y_min) * grid + (i - x_min);
    endfunction

endpackage

// File: rtl/iq_hist_bank.sv
// iq_hist_bank: NBINS saturating bin counters with an increment port and a read-and-clear port
module iq_hist_bank
    import iq_hist_pkg::*;
#(
    parameter int NBINS = 9,
    parameter int CNT_W = 16,
    parameter int BIN_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc_en,
    input  logic [BIN_W-1:0] inc_bin,
    input  logic             rd_en,
    input  logic [BIN_W-1:0] rd_addr,
    output logic [CNT_W-1:0] rd_data
);

    logic [CNT_W-1:0] cnt_q [NBINS];
    logic [CNT_W-1:0] cnt_d [NBINS];

    // increment saturates at all-ones; a read-and-clear zeroes the addressed bin
    always_comb begin
        for (int k = 0; k < NBINS; k++) begin
            cnt_d[k] = cnt_q[k];
            if (inc_en && inc_bin == BIN_W'(k) && cnt_q[k] != '1) cnt_d[k] = cnt_q[k] + 1'b1;
            if (rd_en && rd_addr == BIN_W'(k)) cnt_d[k] = '0;
        end
    end

    // counter storage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NBINS; k++) cnt_q[k] <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign rd_data = cnt_q[rd_addr];

endmodule

// File: rtl/iq_hist_correlator.sv
// iq_hist_correlator: per-window I/Q constellation histograms of two channels, then a bin-wise MAC
module iq_hist_correlator
    import iq_hist_pkg::*;
#(
    parameter int DATA_W  = 6,
    parameter int GRID    = 3,
    parameter int CNT_W   = 16,
    parameter int WINDOW  = 256,
    parameter int A_X_MIN = 31,
    parameter int A_Y_MIN = 23,
    parameter int B_X_MIN = 31,
    parameter int B_Y_MIN = 39,
    localparam int NBINS  = GRID * GRID,
    localparam int RES_W  = 2 * CNT_W + $clog2(NBINS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              continuous,
    input  logic              abort,
    input  logic              mode,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] a_q,
    input  logic [DATA_W-1:0] b_i,
    input  logic [DATA_W-1:0] b_q,
    output logic [RES_W-1:0]  result,
    output logic              result_valid,
    output logic              busy
);

    localparam int BIN_W = NBINS > 1 ? $clog2(NBINS) : 1;
    localparam int WIN_W = $clog2(WINDOW + 1);

    state_t             state_q, state_d;
    logic [WIN_W-1:0]   win_q, win_d;
    logic [BIN_W-1:0]   k_q, k_d;
    logic [RES_W-1:0]   acc_q, acc_d;
    logic [RES_W-1:0]   result_q, result_d;
    logic               mode_q, mode_d;
    logic               result_valid_q, result_valid_d;
    logic               in_ready_q, in_ready_d;
    logic               busy_q, busy_d;
    logic [CNT_W-1:0]   rd_a, rd_b;

    wire accept   = in_valid && in_ready_q;
    wire kill     = abort && state_q != IDLE;
    wire a_hit    = in_range(int'(a_i), int'(a_q), A_X_MIN, A_Y_MIN, GRID);
    wire b_hit    = in_range(int'(b_i), int'(b_q), B_X_MIN, B_Y_MIN, GRID);
    wire [BIN_W-1:0] a_bin = BIN_W'(bin_idx(int'(a_i), int'(a_q), A_X_MIN, A_Y_MIN, GRID));
    wire [BIN_W-1:0] b_bin = BIN_W'(bin_idx(int'(b_i), int'(b_q), B_X_MIN, B_Y_MIN, GRID));
    wire rd_en    = state_q == MAC || state_q == CLEAR;
    wire last_k   = k_q == BIN_W'(NBINS - 1);
    wire last_win = win_q == WIN_W'(WINDOW - 1);
    wire [CNT_W-1:0] op_b = mode_q ? rd_a : rd_b;
    wire [RES_W-1:0] prod = RES_W'(rd_a) * RES_W'(op_b);

    iq_hist_bank #(.NBINS(NBINS), .CNT_W(CNT_W), .BIN_W(BIN_W)) u_bank_a (
        .clk     (clk),
        .rst_n   (rst_n),
        .inc_en  (accept && !kill && a_hit),
        .inc_bin (a_bin),
        .rd_en   (rd_en),
        .rd_addr (k_q),
        .rd_data (rd_a)
    );

    iq_hist_bank #(.NBINS(NBINS), .CNT_W(CNT_W), .BIN_W(BIN_W)) u_bank_b (
        .clk     (clk),
        .rst_n   (rst_n),
        .inc_en  (accept && !kill && b_hit),
        .inc_bin (b_bin),
        .rd_en   (rd_en),
        .rd_addr (k_q),
        .rd_data (rd_b)
    );

    // next-state: abort preempts everything outside IDLE; the MAC sweep reads and clears one bin per cycle
    always_comb begin
        state_d        = state_q;
        win_d          = win_q;
        k_d            = k_q;
        acc_d          = acc_q;
        mode_d         = mode_q;
        result_d       = result_q;
        result_valid_d = 1'b0;
        if (kill) begin
            state_d = CLEAR;
            k_d     = '0;
            win_d   = '0;
            acc_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = start ? ACCUM : IDLE;
                    win_d   = '0;
                end
                ACCUM: if (accept) begin
                    win_d = win_q + 1'b1;
                    if (last_win) begin
                        state_d = MAC;
                        k_d     = '0;
                        acc_d   = '0;
                        mode_d  = mode;
                    end
                end
                MAC: begin
                    acc_d   = acc_q + prod;
                    k_d     = k_q + 1'b1;
                    state_d = last_k ? DONE : MAC;
                end
                DONE: begin
                    result_d       = acc_q;
                    result_valid_d = 1'b1;
                    win_d          = '0;
                    state_d        = continuous ? ACCUM : IDLE;
                end
                CLEAR: begin
                    k_d     = k_q + 1'b1;
                    win_d   = '0;
                    acc_d   = '0;
                    state_d = last_k ? IDLE : CLEAR;
                end
                default: state_d = IDLE;
            endcase
        end
        in_ready_d = state_d == ACCUM;
        busy_d     = state_d == ACCUM || state_d == MAC || state_d == CLEAR;
    end

    // state, counters and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            win_q          <= '0;
            k_q            <= '0;
            acc_q          <= '0;
            mode_q         <= 1'b0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            in_ready_q     <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            win_q          <= win_d;
            k_q            <= k_d;
            acc_q          <= acc_d;
            mode_q         <= mode_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
            in_ready_q     <= in_ready_d;
            busy_q         <= busy_d;
        end
    end

    assign in_ready     = in_ready_q;
    assign busy         = busy_q;
    assign result       = result_q;
    assign result_valid = result_valid_q;

endmodule

// File: tb/tb_iq_hist_correlator.sv
// tb_iq_hist_correlator: randomized windows checked against a histogram/dot-product reference model
module tb_iq_hist_correlator;

    logic       clk = 0, rst_n = 0;
    logic       start_m = 0, start_s = 0, continuous = 0, abort = 0, mode = 0, in_valid = 0;
    logic [5:0] a_i = 0, a_q = 0, b_i = 0, b_q = 0;
    logic       in_ready_m, in_ready_s, rv_m, rv_s, busy_m, busy_s;
    logic [35:0] result_m;
    logic [7:0]  result_s;

    int n_checks = 0, n_errors = 0;
    int sa_i[16], sa_q[16], sb_i[16], sb_q[16];

    always #5 clk = ~clk;

    iq_hist_correlator #(.WINDOW(4)) dut_m (
        .clk(clk), .rst_n(rst_n), .start(start_m), .continuous(continuous), .abort(abort),
        .mode(mode), .in_valid(in_valid), .in_ready(in_ready_m), .a_i(a_i), .a_q(a_q),
        .b_i(b_i), .b_q(b_q), .result(result_m), .result_valid(rv_m), .busy(busy_m)
    );

    iq_hist_correlator #(.CNT_W(2), .WINDOW(8)) dut_s (
        .clk(clk), .rst_n(rst_n), .start(start_s), .continuous(continuous), .abort(abort),
        .mode(mode), .in_valid(in_valid), .in_ready(in_ready_s), .a_i(a_i), .a_q(a_q),
        .b_i(b_i), .b_q(b_q), .result(result_s), .result_valid(rv_s), .busy(busy_s)
    );

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // reference: build both histograms from the samples, saturate at cap, then dot product
    function automatic longint model(input int n, input int cap, input bit md);
        int ha[9], hb[9];
        longint s = 0;
        for (int j = 0; j < 9; j++) begin ha[j] = 0; hb[j] = 0; end
        for (int k = 0; k < n; k++) begin
            int ax = sa_i[k] - 31, ay = sa_q[k] - 23, bx = sb_i[k] - 31, by = sb_q[k] - 39;
            if (ax >= 0 && ax < 3 && ay >= 0 && ay < 3 && ha[ay*3+ax] < cap) ha[ay*3+ax]++;
            if (bx >= 0 && bx < 3 && by >= 0 && by < 3 && hb[by*3+bx] < cap) hb[by*3+bx]++;
        end
        for (int j = 0; j < 9; j++) s += longint'(ha[j]) * (md ? ha[j] : hb[j]);
        return s;
    endfunction

    task automatic set_all(input int n, input int ai, input int aq, input int bi, input int bq);
        for (int k = 0; k < n; k++) begin sa_i[k] = ai; sa_q[k] = aq; sb_i[k] = bi; sb_q[k] = bq; end
    endtask

    task automatic set_random(input int n);
        for (int k = 0; k < n; k++) begin
            if ($urandom_range(0, 7) == 0) begin
                sa_i[k] = $urandom_range(0, 63); sa_q[k] = $urandom_range(0, 63);
                sb_i[k] = $urandom_range(0, 63); sb_q[k] = $urandom_range(0, 63);
            end else begin
                sa_i[k] = 30 + $urandom_range(0, 4); sa_q[k] = 22 + $urandom_range(0, 4);
                sb_i[k] = 30 + $urandom_range(0, 4); sb_q[k] = 38 + $urandom_range(0, 4);
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input bit sel);
        if (sel) start_s = 1; else start_m = 1;
        cycle();
        start_m = 0;
        start_s = 0;
    endtask

    // present samples with random bubbles until n are accepted
    task automatic feed(input int n, input bit sel);
        int k = 0, guard = 0;
        bit rdy;
        while (k < n && guard < 200) begin
            in_valid = ($urandom_range(0, 3) != 0);
            a_i = 6'(sa_i[k]); a_q = 6'(sa_q[k]); b_i = 6'(sb_i[k]); b_q = 6'(sb_q[k]);
            rdy = sel ? in_ready_s : in_ready_m;
            cycle();
            if (in_valid && rdy) k++;
            guard++;
        end
        in_valid = 0;
        check("feed_accepts", k, n);
    endtask

    task automatic wait_result(input string tag, input bit sel, input longint exp);
        int n = 0;
        bit seen = 0;
        while (n < 40 && !seen) begin
            cycle();
            n++;
            seen = sel ? rv_s : rv_m;
        end
        check({tag, "_latency"}, n, 10);
        check({tag, "_result"}, sel ? longint'(result_s) : longint'(result_m), exp);
        cycle();
        check({tag, "_rv_low"}, sel ? rv_s : rv_m, 0);
    endtask

    task automatic run_window(input string tag, input int n, input bit md, input bit sel);
        mode = md;
        do_start(sel);
        feed(n, sel);
        wait_result(tag, sel, model(n, sel ? 3 : 65535, md));
    endtask

    initial begin
        longint saved;
        int cnt, pulses;
        #3;
        check("rst_result", result_m, 0);
        check("rst_rv", rv_m, 0);
        check("rst_ready", in_ready_m, 0);
        check("rst_busy", busy_m, 0);
        #20 rst_n = 1;
        cycle();
        check("idle_busy", busy_s, 0);

        set_all(4, 32, 24, 32, 40);
        run_window("same_bin", 4, 0, 0);
        check("same_bin_idle", busy_m, 0);

        set_all(4, 31, 23, 33, 41);
        run_window("disjoint", 4, 0, 0);

        set_all(4, 31, 23, 31, 39);
        sa_i[2] = 32; sa_i[3] = 60; sa_q[3] = 0;
        run_window("auto", 4, 1, 0);

        set_all(8, 31, 23, 31, 39);
        run_window("saturate", 8, 0, 1);

        continuous = 1;
        set_all(4, 32, 24, 32, 40);
        run_window("cont1", 4, 0, 0);
        check("cont_ready", in_ready_m, 1);
        feed(4, 0);
        continuous = 0;
        wait_result("cont2", 0, model(4, 65535, 0));
        check("cont_end_ready", in_ready_m, 0);

        saved = longint'(result_m);
        set_random(4);
        do_start(0);
        feed(2, 0);
        abort = 1;
        cycle();
        abort = 0;
        check("abort_busy", busy_m, 1);
        check("abort_ready", in_ready_m, 0);
        cnt = 0; pulses = 0;
        while (busy_m && cnt < 40) begin
            cycle();
            cnt++;
            pulses += rv_m;
        end
        check("clear_cycles", cnt, 9);
        check("abort_no_pulse", pulses, 0);
        check("abort_result_kept", result_m, saved);
        set_random(4);
        run_window("after_abort", 4, 1, 0);

        set_all(4, 32, 24, 32, 40);
        do_start(0);
        feed(4, 0);
        cycle(); cycle(); cycle();
        rst_n = 0;
        #2;
        check("midmac_result", result_m, 0);
        check("midmac_rv", rv_m, 0);
        check("midmac_busy", busy_m, 0);
        check("midmac_ready", in_ready_m, 0);
        rst_n = 1;
        pulses = 0;
        for (int c = 0; c < 15; c++) begin cycle(); pulses += rv_m; end
        check("midmac_no_pulse", pulses, 0);
        set_random(4);
        run_window("after_reset", 4, 0, 0);

        for (int r = 0; r < 8; r++) begin
            set_random(4);
            run_window("rand_m", 4, 1'($urandom_range(0, 1)), 0);
        end
        for (int r = 0; r < 3; r++) begin
            set_random(8);
            run_window("rand_s", 8, 1'($urandom_range(0, 1)), 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
